// File: rtl/rule90_pkg.sv
// rule90_pkg
//   Shared definitions for the Rule 90 reverse stepper:
//     - state_t          : controller states {IDLE, SWEEP, DONE}
//     - DEFAULT_W        : default cell count (even, >= 4)
//     - DEFAULT_STEPS_W  : default width of the step-count field
//     - MAX_W            : widest cell count rule90_step can handle
//     - rule90_step()    : one forward Rule 90 generation, zero boundaries
package rule90_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_W       = 512;
    localparam int DEFAULT_STEPS_W = 8;
    localparam int MAX_W           = 1024;

    // Forward generation of the low w cells of s: f[i] = s[i-1] ^ s[i+1].
    // Cells outside 0..w-1 read as zero. Result bits at or above w are zero.
    function automatic logic [MAX_W-1:0] rule90_step(input logic [MAX_W-1:0] s,
                                                     input int w);
        logic [MAX_W-1:0] f;
        logic             left;
        logic             right;
        f = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < w) begin
                // The inner ternaries keep every select in range; the outer
                // ones apply the zero boundary.
                left  = (i > 0)     ? s[(i > 0) ? i - 1 : 0]             : 1'b0;
                right = (i < w - 1) ? s[(i < MAX_W - 1) ? i + 1 : i]     : 1'b0;
                f[i]  = left ^ right;
            end
        end
        return f;
    endfunction

endpackage

// File: rtl/rule90_fwd_step.sv
// rule90_fwd_step
//   Combinational single forward Rule 90 generation of a W-cell row with
//   zero boundaries. Used to re-check each reverse generation.
//   Ports:
//     state      in  [W-1:0]  current row, bit i = cell i
//     next_state out [W-1:0]  row one generation later
module rule90_fwd_step
    import rule90_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic [W-1:0] state,
    output logic [W-1:0] next_state
);

    assign next_state = W'(rule90_step(MAX_W'(state), W));

endmodule

// File: rtl/rule90_reverse.sv
// rule90_reverse
//   Computes the N-th predecessor of a Rule 90 row (zero boundaries, even W).
//   A generation is solved serially, one odd and one even cell per cycle:
//     odd cells ascend   : p[1] = s[0],   p[2k+1] = s[2k]   ^ p[2k-1]
//     even cells descend : p[W-2] = s[W-1], p[2j] = s[2j+1] ^ p[2j+2]
//   so each generation takes W/2 cycles and no long XOR chain is built.
//   Optional build macro RULE90_VERIFY_EN adds a sticky `err` output that
//   steps every completed generation forward and compares it with its source.
//   Ports:
//     clk        in   clock, rising edge
//     resetn     in   synchronous active-low reset
//     in_valid   in   request valid
//     in_ready   out  high only in IDLE
//     in_data    in   [W-1:0] target row s
//     in_steps   in   [STEPS_W-1:0] number of reverse generations N
//     out_valid  out  result valid (DONE)
//     out_ready  in   result consumed
//     out_data   out  [W-1:0] predecessor row p, held through DONE
//     busy       out  high in SWEEP
//     err        out  (RULE90_VERIFY_EN only) forward re-check mismatch
//   W must be even, >= 4 and <= MAX_W.
module rule90_reverse
    import rule90_pkg::*;
#(
    parameter int W       = DEFAULT_W,
    parameter int STEPS_W = DEFAULT_STEPS_W
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W-1:0]       in_data,
    input  logic [STEPS_W-1:0] in_steps,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [W-1:0]       out_data,
    output logic               busy
`ifdef RULE90_VERIFY_EN
    ,
    output logic               err
`endif
);

    localparam int HALF = W / 2;
    localparam int K_W  = (HALF > 1) ? $clog2(HALF) : 1;

    localparam logic [K_W-1:0]     K_LAST   = K_W'(HALF - 1);
    localparam logic [K_W-1:0]     K_ONE    = K_W'(1);
    localparam logic [STEPS_W-1:0] STEP_ONE = STEPS_W'(1);

    state_t             state_reg,   state_next;
    logic [W-1:0]       cur_reg,     cur_next;
    logic [W-1:0]       nxt_reg,     nxt_next;
    logic [K_W-1:0]     k_reg,       k_next;
    logic [STEPS_W-1:0] stepcnt_reg, stepcnt_next;
    logic [W-1:0]       out_data_reg, out_data_next;

    logic [K_W-1:0]     j;
    logic [K_W:0]       odd_idx;
    logic [K_W:0]       even_idx;
    logic               odd_bit;
    logic               even_bit;
    logic [W-1:0]       nxt_upd;

    // Mirror position of k for the descending even sweep.
    assign j        = K_LAST - k_reg;
    assign odd_idx  = {k_reg, 1'b1};
    assign even_idx = {j, 1'b0};

    // Both cells read the partner computed in an earlier cycle of the same
    // generation; the first cell of each sweep comes straight from cur.
    assign odd_bit  = (k_reg == '0) ? cur_reg[0]
                    : cur_reg[{k_reg, 1'b0}] ^ nxt_reg[{k_reg - K_ONE, 1'b1}];
    assign even_bit = (j == K_LAST) ? cur_reg[W-1]
                    : cur_reg[{j, 1'b1}] ^ nxt_reg[{j + K_ONE, 1'b0}];

    // nxt with this cycle's two resolved cells merged in. At k == W/2-1 this
    // is the completed predecessor generation.
    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_upd
            if (gi % 2 == 1) begin : g_odd
                assign nxt_upd[gi] = (odd_idx == (K_W + 1)'(gi)) ? odd_bit : nxt_reg[gi];
            end else begin : g_even
                assign nxt_upd[gi] = (even_idx == (K_W + 1)'(gi)) ? even_bit : nxt_reg[gi];
            end
        end
    endgenerate

    always_comb begin
        state_next    = state_reg;
        cur_next      = cur_reg;
        nxt_next      = nxt_reg;
        k_next        = k_reg;
        stepcnt_next  = stepcnt_reg;
        out_data_next = out_data_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    cur_next     = in_data;
                    stepcnt_next = in_steps;
                    k_next       = '0;
                    if (in_steps == '0) begin
                        out_data_next = in_data;
                        state_next    = DONE;
                    end else begin
                        state_next    = SWEEP;
                    end
                end
            end
            SWEEP: begin
                nxt_next = nxt_upd;
                if (k_reg == K_LAST) begin
                    cur_next     = nxt_upd;
                    stepcnt_next = stepcnt_reg - STEP_ONE;
                    k_next       = '0;
                    if (stepcnt_reg == STEP_ONE) begin
                        out_data_next = nxt_upd;
                        state_next    = DONE;
                    end
                end else begin
                    k_next = k_reg + K_ONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg    <= IDLE;
            cur_reg      <= '0;
            nxt_reg      <= '0;
            k_reg        <= '0;
            stepcnt_reg  <= '0;
            out_data_reg <= '0;
        end else begin
            state_reg    <= state_next;
            cur_reg      <= cur_next;
            nxt_reg      <= nxt_next;
            k_reg        <= k_next;
            stepcnt_reg  <= stepcnt_next;
            out_data_reg <= out_data_next;
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign busy      = (state_reg == SWEEP);
    assign out_data  = out_data_reg;

`ifdef RULE90_VERIFY_EN
    logic [W-1:0] fwd;
    logic         err_reg;
    logic         gen_end;
    logic         accept;

    rule90_fwd_step #(
        .W (W)
    ) u_fwd (
        .state      (nxt_upd),
        .next_state (fwd)
    );

    assign gen_end = (state_reg == SWEEP) && (k_reg == K_LAST);
    assign accept  = (state_reg == IDLE) && in_valid;

    // Sticky until reset or the next accepted request.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            err_reg <= 1'b0;
        end else if (accept) begin
            err_reg <= 1'b0;
        end else if (gen_end && (fwd != cur_reg)) begin
            err_reg <= 1'b1;
        end
    end

    assign err = err_reg;
`endif

endmodule

// File: tb/tb_rule90_reverse.sv
module tb_rule90_reverse;
    import rule90_pkg::*;

    localparam int W       = 512;
    localparam int STEPS_W = 8;
    localparam int HALF    = W / 2;
    localparam int LIMIT   = 4000;

    logic               clk;
    logic               resetn;
    logic               in_valid;
    logic               in_ready;
    logic [W-1:0]       in_data;
    logic [STEPS_W-1:0] in_steps;
    logic               out_valid;
    logic               out_ready;
    logic [W-1:0]       out_data;
    logic               busy;
`ifdef RULE90_VERIFY_EN
    logic               err;
`endif

    int total_cnt = 0;
    int pass_cnt  = 0;

    rule90_reverse #(
        .W       (W),
        .STEPS_W (STEPS_W)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_steps  (in_steps),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
`ifdef RULE90_VERIFY_EN
        ,
        .err       (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: forward-step the candidate predecessor n times.
    function automatic logic [W-1:0] fwd_n(input logic [W-1:0] x, input int n);
        logic [W-1:0] y;
        y = x;
        for (int i = 0; i < n; i++) begin
            y = W'(rule90_step(MAX_W'(y), W));
        end
        return y;
    endfunction

    function automatic logic [W-1:0] rand_row();
        logic [W-1:0] r;
        for (int i = 0; i < W / 32; i++) begin
            r[i*32 +: 32] = $urandom();
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
            $display("check %-22s ok   value %0h", tag, obs);
        end else begin
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request and check latency and result. Leaves the bench one
    // cycle after the result handshake when out_ready is high.
    task automatic run_job(input string tag, input logic [W-1:0] data, input int n,
                           input logic [W-1:0] exp, input bit consume);
        int cyc;
        cyc = 0;
        while (in_ready !== 1'b1 && cyc < LIMIT) begin
            tick();
            cyc++;
        end
        check({tag, "_in_ready"}, W'(in_ready), W'(1));
        in_valid = 1'b1;
        in_data  = data;
        in_steps = STEPS_W'(n);
        tick();
        in_valid = 1'b0;
        in_data  = rand_row();   // must be ignored outside accept
        in_steps = STEPS_W'($urandom_range(0, 255));
        if (n > 0) begin
            check({tag, "_busy"}, W'(busy), W'(1));
        end
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < LIMIT) begin
            tick();
            cyc++;
        end
        check({tag, "_latency"}, W'(cyc), W'(n * HALF));
        check({tag, "_data"}, out_data, exp);
`ifdef RULE90_VERIFY_EN
        check({tag, "_err"}, W'(err), W'(0));
`endif
        if (consume) begin
            tick();
            check({tag, "_release"}, W'(out_valid), W'(0));
        end
    endtask

    initial begin
        logic [W-1:0] p;
        logic [W-1:0] s;
        logic [W-1:0] exp;
        int           n;

        resetn    = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_steps  = '0;
        out_ready = 1'b1;
        repeat (3) tick();
        resetn = 1'b1;
        tick();
        check("rst_out_valid", W'(out_valid), W'(0));
        check("rst_out_data", out_data, '0);
        check("rst_in_ready", W'(in_ready), W'(1));
        check("rst_busy", W'(busy), W'(0));

        // Cells 4 and 6 -> single cell 5.
        s = '0; s[4] = 1'b1; s[6] = 1'b1;
        exp = '0; exp[5] = 1'b1;
        run_job("bits46", s, 1, exp, 1'b1);

        // Cell 0 -> every odd cell.
        s = '0; s[0] = 1'b1;
        for (int i = 1; i < W; i += 2) exp[i] = 1'b1;
        for (int i = 0; i < W; i += 2) exp[i] = 1'b0;
        run_job("bit0", s, 1, exp, 1'b1);

        // Random predecessor, three generations.
        p = rand_row();
        run_job("rand_n3", fwd_n(p, 3), 3, p, 1'b1);

        // N == 0 returns the input unchanged, next cycle.
        s = rand_row();
        run_job("n0", s, 0, s, 1'b1);

        // A few more random jobs.
        for (int r = 0; r < 3; r++) begin
            p = rand_row();
            n = $urandom_range(1, 2);
            run_job($sformatf("rand%0d_n%0d", r, n), fwd_n(p, n), n, p, 1'b1);
        end

        // Stall in DONE: result held, in_ready low, new requests ignored.
        out_ready = 1'b0;
        p = rand_row();
        run_job("stall", fwd_n(p, 1), 1, p, 1'b0);
        for (int c = 0; c < 10; c++) begin
            in_valid = c[0];
            in_data  = rand_row();
            in_steps = STEPS_W'(0);
            tick();
            check($sformatf("stall%0d_valid", c), W'(out_valid), W'(1));
            check($sformatf("stall%0d_data", c), out_data, p);
            check($sformatf("stall%0d_in_ready", c), W'(in_ready), W'(0));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("stall_release_valid", W'(out_valid), W'(0));
        check("stall_release_ready", W'(in_ready), W'(1));

        // Reset at k=100 of the first generation.
        p = rand_row();
        in_valid = 1'b1;
        in_data  = fwd_n(p, 2);
        in_steps = STEPS_W'(2);
        tick();
        in_valid = 1'b0;
        repeat (100) tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        check("midrst_out_valid", W'(out_valid), W'(0));
        check("midrst_out_data", out_data, '0);
        check("midrst_in_ready", W'(in_ready), W'(1));
        check("midrst_busy", W'(busy), W'(0));
        run_job("after_rst", fwd_n(p, 2), 2, p, 1'b1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
